// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// fb_pkg : shared constants, pipeline record and factor clamp for fb_scanout
// Rev    : 1.0
// ============================================================================
package fb_pkg;

  localparam int FB_LARGURA = 160;
  localparam int FB_ALTURA  = 120;
  localparam int FB_H_ACT   = 640;
  localparam int FB_H_FP    = 16;
  localparam int FB_H_SYNC  = 96;
  localparam int FB_H_BP    = 48;
  localparam int FB_V_ACT   = 480;
  localparam int FB_V_FP    = 10;
  localparam int FB_V_SYNC  = 2;
  localparam int FB_V_BP    = 33;

  localparam int ADDR_W = 19;
  localparam int PIX_W  = 8;
  localparam int CRD_W  = 10;

  typedef enum logic [1:0] {
    SRC_BLANK  = 2'd0,
    SRC_BORDER = 2'd1,
    SRC_RAM    = 2'd2
  } pix_src_e;

  // Everything that must stay aligned with the RAM data as it moves down the pipe
  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             fs;
    pix_src_e         src;
    logic [CRD_W-1:0] x;
    logic [CRD_W-1:0] y;
  } pipe_t;

  localparam pipe_t PIPE_RST = '{hsync: 1'b1, vsync: 1'b1, fs: 1'b0,
                                 src: SRC_BLANK, x: '0, y: '0};

  function automatic logic [2:0] clamp_fator(input logic [2:0] f);
    logic [2:0] r;
    r = f;
    if (f == 3'd0) r = 3'd1;
    else if (f > 3'd4) r = 3'd4;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : free-running h/v raster counters with raw (S0) syncs/flags
// Rev            : 1.0
// ============================================================================
module vga_timing_gen
  import fb_pkg::*;
#(
  parameter int H_ACT  = FB_H_ACT,
  parameter int H_FP   = FB_H_FP,
  parameter int H_SYNC = FB_H_SYNC,
  parameter int H_BP   = FB_H_BP,
  parameter int V_ACT  = FB_V_ACT,
  parameter int V_FP   = FB_V_FP,
  parameter int V_SYNC = FB_V_SYNC,
  parameter int V_BP   = FB_V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CRD_W-1:0] h,
  output logic [CRD_W-1:0] v,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             active,
  output logic             frame_start
);

  localparam logic [CRD_W-1:0] H_LAST = CRD_W'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CRD_W-1:0] V_LAST = CRD_W'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CRD_W-1:0] H_SS   = CRD_W'(H_ACT + H_FP);
  localparam logic [CRD_W-1:0] H_SE   = CRD_W'(H_ACT + H_FP + H_SYNC);
  localparam logic [CRD_W-1:0] V_SS   = CRD_W'(V_ACT + V_FP);
  localparam logic [CRD_W-1:0] V_SE   = CRD_W'(V_ACT + V_FP + V_SYNC);
  localparam logic [CRD_W-1:0] H_ACTW = CRD_W'(H_ACT);
  localparam logic [CRD_W-1:0] V_ACTW = CRD_W'(V_ACT);

  logic [CRD_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q + CRD_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CRD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h           = h_q;
  assign v           = v_q;
  assign hsync_raw   = !((h_q >= H_SS) && (h_q < H_SE));
  assign vsync_raw   = !((v_q >= V_SS) && (v_q < V_SE));
  assign active      = (h_q < H_ACTW) && (v_q < V_ACTW);
  assign frame_start = (h_q == '0) && (v_q == '0);

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// fb_scanout : raster reader for the zoom frame buffer, image centred on screen
// Rev        : 1.0
// ============================================================================
module fb_scanout
  import fb_pkg::*;
#(
  parameter int               LARGURA = FB_LARGURA,
  parameter int               ALTURA  = FB_ALTURA,
  parameter int               H_ACT   = FB_H_ACT,
  parameter int               H_FP    = FB_H_FP,
  parameter int               H_SYNC  = FB_H_SYNC,
  parameter int               H_BP    = FB_H_BP,
  parameter int               V_ACT   = FB_V_ACT,
  parameter int               V_FP    = FB_V_FP,
  parameter int               V_SYNC  = FB_V_SYNC,
  parameter int               V_BP    = FB_V_BP,
  parameter logic [PIX_W-1:0] BORDER  = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        fator,
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [PIX_W-1:0]  ram_data,
  output logic              hsync,
  output logic              vsync,
  output logic              pix_valid,
  output logic [CRD_W-1:0]  pix_x,
  output logic [CRD_W-1:0]  pix_y,
  output logic [PIX_W-1:0]  pixel,
  output logic              frame_start
);

  localparam logic [10:0] H_ACTW = 11'(H_ACT);
  localparam logic [10:0] V_ACTW = 11'(V_ACT);
  localparam logic [10:0] LARGW  = 11'(LARGURA);
  localparam logic [10:0] ALTW   = 11'(ALTURA);

  logic [CRD_W-1:0]  h, v;
  logic              hs0, vs0, act0, fs0;
  logic [2:0]        f_q, f_d, f_cur;
  logic [10:0]       win_w, win_h, x0, y0;
  logic              in_win;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d, addr_base, rdaddr_q, rdaddr_d;
  pipe_t             s0, s1_q, s2_q, out_q;
  logic [PIX_W-1:0]  pixel_q, pixel_d;

  vga_timing_gen #(
    .H_ACT (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACT (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .h           (h),
    .v           (v),
    .hsync_raw   (hs0),
    .vsync_raw   (vs0),
    .active      (act0),
    .frame_start (fs0)
  );

  // S0: the (0,0) cycle already decodes with the freshly latched factor
  always_comb begin
    f_cur  = fs0 ? clamp_fator(fator) : f_q;
    f_d    = f_cur;
    win_w  = LARGW * 11'(f_cur);
    win_h  = ALTW * 11'(f_cur);
    x0     = (H_ACTW - win_w) >> 1;
    y0     = (V_ACTW - win_h) >> 1;
    in_win = act0 &&
             ({1'b0, h} >= x0) && ({1'b0, h} < x0 + win_w) &&
             ({1'b0, v} >= y0) && ({1'b0, v} < y0 + win_h);
    addr_base  = fs0 ? '0 : addr_cnt_q;
    addr_cnt_d = in_win ? addr_base + ADDR_W'(1) : addr_base;
    rdaddr_d   = in_win ? addr_base : rdaddr_q;
    s0 = '{hsync: hs0, vsync: vs0, fs: fs0,
           src:   in_win ? SRC_RAM : (act0 ? SRC_BORDER : SRC_BLANK),
           x:     act0 ? h : '0,
           y:     act0 ? v : '0};
  end

  // S2: RAM data for this pixel is on ram_data now
  always_comb begin
    case (s2_q.src)
      SRC_RAM:    pixel_d = ram_data;
      SRC_BORDER: pixel_d = BORDER;
      default:    pixel_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_q        <= 3'd1;
      addr_cnt_q <= '0;
      rdaddr_q   <= '0;
      s1_q       <= PIPE_RST;
      s2_q       <= PIPE_RST;
      out_q      <= PIPE_RST;
      pixel_q    <= '0;
    end else begin
      f_q        <= f_d;
      addr_cnt_q <= addr_cnt_d;
      rdaddr_q   <= rdaddr_d;
      s1_q       <= s0;
      s2_q       <= s1_q;
      out_q      <= s2_q;
      pixel_q    <= pixel_d;
    end
  end

  assign ram_rdaddr  = rdaddr_q;
  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign pix_valid   = (out_q.src != SRC_BLANK);
  assign pix_x       = out_q.x;
  assign pix_y       = out_q.y;
  assign pixel       = pixel_q;
  assign frame_start = out_q.fs;

endmodule
`default_nettype wire

// File: doc/fb_scanout.md
# fb_scanout

Display-side reader for the zoom frame buffer. It generates 640x480 raster timing, reads the zoomed image from the frame-buffer RAM, and outputs one pixel per clock. The image is `LARGURA*f` x `ALTURA*f` and sits centred on screen. The zoom unit writes this RAM; this block sits between that RAM and the video DAC/VGA pins.

## Interface
Parameters:
- `LARGURA`, 160, source image width before zoom
- `ALTURA`, 120, source image height before zoom
- `H_ACT`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48, horizontal timing in clocks
- `V_ACT`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33, vertical timing in lines
- `BORDER`, 8'h00, pixel value inside the active area but outside the image

Ports:
- `clk`, in, 1: pixel clock
- `reset`, in, 1: asynchronous, active-low
- `fator`, in, 3: zoom factor
- `ram_rdaddr`, out, 19: frame-buffer read address
- `ram_data`, in, 8: RAM read data, synchronous, 1-cycle latency
- `hsync`, `vsync`, out, 1 each: active-low syncs
- `pix_valid`, out, 1: high inside the 640x480 active area
- `pix_x`, `pix_y`, out, 10 each: active-area coordinates, 0 when not valid
- `pixel`, out, 8: pixel value
- `frame_start`, out, 1: one-cycle pulse aligned with output pixel (0,0)

## Operation
- Raster counters:
  - `h` runs 0..799 and wraps to 0; `v` increments on each `h` wrap and runs 0..524, wrapping to 0.
  - hsync is low for `h` in 656..751; vsync is low for `v` in 490..491.
- Factor latch:
  - `f_q` loads from `fator` only when `h==0 && v==0`. A change mid-frame takes effect on the next frame, with no tearing.
  - Clamping: 0 becomes 1; 5..7 become 4.
- Window:
  - `W=LARGURA*f_q`, `H=ALTURA*f_q`, `X0=(640-W)/2`, `Y0=(480-H)/2`.
  - Values by factor: f=1 gives 160x120 at (240,180); f=2 gives 320x240 at (160,120); f=3 gives 480x360 at (80,60); f=4 gives 640x480 at (0,0).
  - In-window means `X0<=h<X0+W` and `Y0<=v<Y0+H`.
- Address generation:
  - Incremental, no per-pixel multiplier. `addr_cnt` clears to 0 at `h==0 && v==0` and increments by 1 on every in-window cycle.
  - `ram_rdaddr<=addr_cnt` on in-window cycles; otherwise `ram_rdaddr` holds its value.
  - Maximum address is 307199, so 19 bits cannot overflow.
- Pixel select:
  - in-window gives `ram_data`;
  - active but not in-window gives `BORDER`;
  - blanking gives 0.
- Reset values:
  - `h=v=0`, `addr_cnt=0`, `ram_rdaddr=0`, `f_q=1`;
  - `hsync=vsync=1`, `pix_valid=0`, `pix_x=pix_y=0`, `pixel=0`, `frame_start=0`.
- Reset mid-frame aborts immediately to the reset values. Scanning restarts at (0,0) on the first clock after release.

## Timing
- Three-stage pipeline:
  - S0: counters and window decode.
  - S1: `ram_rdaddr` register; the RAM samples it.
  - S2: `ram_data` valid; the `pixel` register loads.
- All outputs are delayed exactly 3 clocks from the S0 counter values: `hsync`, `vsync`, `pix_valid`, `pix_x`, `pix_y`, `pixel`, `frame_start`. Sync, flags and data stay mutually aligned.
- Window/source flags travel through the pipeline with the data, so the border/blank select at S2 uses S0's decision.
- The block is free-running: no stall or backpressure, one pixel per clock, 420000 clocks per frame.

## Structure
- Package `fb_pkg` holds:
  - the timing constants, `LARGURA`/`ALTURA`;
  - `ADDR_W=19`, `PIX_W=8`;
  - a function `clamp_fator(3b)->3b`.
- Sub-module `vga_timing_gen`: `h`/`v` counters, raw sync, active flag, frame-start strobe at S0. `fb_scanout` adds the window logic, addressing and the delay pipeline.

## Test plan
- Reset: hold `reset=0` for 5 clocks → `hsync=vsync=1`, `pix_valid=0`, `pixel=0`, `ram_rdaddr=0`. Release → first `frame_start` appears 3 clocks after release.
- f=1, RAM model `data=addr[7:0]`:
  - output (240,180) has pixel 0x00; (399,180) has 0x9F;
  - (240,181) has 160&0xFF=0xA0; (239,180) has `BORDER`;
  - the last in-window address is 19199.
- f=4: all 307200 active pixels come from RAM; `ram_rdaddr` reaches 307199 at output (639,479); no `BORDER` pixels appear.
- Factor change: switch `fator` 1→3 at v=200 → current frame stays 160x120; next frame window is 480x360 at (80,60). `fator=0` behaves as 1; `fator=7` behaves as 4.
- Sync timing: `hsync` low for 96 clocks per line; `vsync` low for 2 lines (1600 clocks); `pix_valid` high for exactly 640 clocks on each of 480 lines; the 3-cycle alignment is checked against a reference counter.
- Reset mid-frame at (300,250), then release → raster restarts at (0,0); `addr_cnt` restarts at 0; no stale pixel is output.
